bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 96 +++++++++
 tb/tb_bin2bcd_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to packed BCD converter
// One bit per cycle; bcd only updates on the done edge so the display never sees partial sums.
module bin2bcd_seq #(
  parameter int WIDTH  = 24,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0]   acc;
  logic [BW-1:0]   acc_adj;
  logic [BW-1:0]   acc_nxt;
  logic [CW-1:0]   cnt;
  logic            last;

  assign last = (cnt == LAST);

  // add-3 correction on every digit, then shift the binary MSB into the accumulator
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
    acc_nxt = (acc_adj << 1) | BW'(sr[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      acc  <= '0;
      cnt  <= '0;
      bcd  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr  <= bin;
            acc <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sr  <= sr << 1;
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            bcd  <= acc_nxt;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq
// Expected BCD values are queued at start acceptance and popped on each done pulse.
module tb_bin2bcd_seq;

  localparam int W = 24;
  localparam int D = 8;

  logic            clk;
  logic            rst;
  logic            start;
  logic [W-1:0]    bin;
  logic            busy;
  logic            done;
  logic [4*D-1:0]  bcd;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  int          m_left;
  logic        m_done;
  logic [31:0] m_bcd;
  logic [31:0] popped;
  logic        seen_done;

  bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // drive one cycle, advance the reference model across the edge, then compare
  task automatic step(input logic st, input logic [W-1:0] b, input logic r);
    start = st;
    bin   = b;
    rst   = r;
    @(posedge clk);
    #1;
    m_done = 1'b0;
    if (r) begin
      m_left = 0;
      exp_q.delete();
      m_bcd = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (st) begin
      m_left = W;
      exp_q.push_back(to_bcd(32'(b)));
    end
    check("busy", 64'(busy), 64'(m_left > 0));
    check("done", 64'(done), 64'(m_done));
    if (done) begin
      if (exp_q.size() == 0) begin
        check("done_without_request", 64'(done), 64'd0);
      end else begin
        popped = exp_q.pop_front();
        check("bcd_result", 64'(bcd), 64'(popped));
        m_bcd = popped;
      end
    end
    check("bcd_hold", 64'(bcd), 64'(m_bcd));
  endtask

  task automatic wait_done();
    seen_done = 1'b0;
    for (int i = 0; i < W + 4 && !seen_done; i++) begin
      step(1'b0, '0, 1'b0);
      if (done) seen_done = 1'b1;
    end
    if (!seen_done) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    m_left = 0;
    m_done = 1'b0;
    m_bcd  = '0;
    start  = 1'b0;
    bin    = '0;
    rst    = 1'b1;

    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    step(1'b1, 24'h003039, 1'b0);
    wait_done();
    check("bcd_12345", 64'(bcd), 64'h00012345);

    step(1'b1, 24'hFFFFFF, 1'b0);
    wait_done();
    check("bcd_max", 64'(bcd), 64'h16777215);
    step(1'b1, 24'h000000, 1'b0);
    wait_done();
    check("bcd_zero", 64'(bcd), 64'h00000000);

    step(1'b1, 24'h0F4240, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 24'h0F4240, 1'b0);
    step(1'b1, 24'h000001, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 24'h00ABCD, 1'b0);
    wait_done();
    check("bcd_ignored_start", 64'(bcd), 64'h01000000);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    step(1'b1, 24'h98967F, 1'b0);
    wait_done();
    check("bcd_9999999", 64'(bcd), 64'h09999999);
    step(1'b1, 24'h00000A, 1'b0);
    wait_done();
    check("bcd_back_to_back", 64'(bcd), 64'h00000010);

    step(1'b1, 24'h123456, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    check("bcd_after_abort", 64'(bcd), 64'd0);
    for (int i = 0; i < W + 4; i++) step(1'b0, '0, 1'b0);
    step(1'b1, 24'h000063, 1'b0);
    wait_done();
    check("bcd_99", 64'(bcd), 64'h00000099);

    step(1'b1, 24'h000005, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      step(1'b1, W'($urandom), 1'b0);
      wait_done();
    end
    step(1'b0, '0, 1'b0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
